// File: rtl/serial_subtractor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor_pkg
// Description : Shared state encoding and default width for serial_subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_subtractor_pkg;

    localparam int SUB_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/serial_subtractor_cell.sv
`default_nettype none
// ============================================================================
// Module      : subtractor
// Description : 1-bit full subtractor cell: diff = a - b - b_in, borrow out.
// Revision    : 1.0 - initial release
// ============================================================================
module subtractor (
    input  logic a,
    input  logic b,
    input  logic b_in,
    output logic diff,
    output logic b_out
);

    assign diff  = a ^ b ^ b_in;
    assign b_out = (~a & (b | b_in)) | (b & b_in);

endmodule
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial unsigned subtractor, LSB first, one bit per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int                c_CNT_W = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

    state_t              r_state;
    logic [WIDTH-1:0]    r_op_a;
    logic [WIDTH-1:0]    r_op_b;
    logic [WIDTH-1:0]    r_result;
    logic                r_borrow;
    logic [c_CNT_W-1:0]  r_count;

    logic                w_cell_diff;
    logic                w_cell_bout;

    subtractor u_cell (
        .a     (r_op_a[0]),
        .b     (r_op_b[0]),
        .b_in  (r_borrow),
        .diff  (w_cell_diff),
        .b_out (w_cell_bout)
    );

    // busy/done are flopped from the state, so they trail it by one cycle;
    // diff/borrow_out load on the SHIFT->DONE edge and are stable before done.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_result   <= '0;
            r_borrow   <= 1'b0;
            r_count    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else begin
            busy <= (r_state == SHIFT);
            done <= (r_state == DONE);
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_op_a   <= a;
                        r_op_b   <= b;
                        r_borrow <= 1'b0;
                        r_count  <= '0;
                        r_state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_result <= {w_cell_diff, r_result[WIDTH-1:1]};
                    r_op_a   <= r_op_a >> 1;
                    r_op_b   <= r_op_b >> 1;
                    r_borrow <= w_cell_bout;
                    r_count  <= r_count + 1'b1;
                    if (r_count == c_LAST) begin
                        diff       <= {w_cell_diff, r_result[WIDTH-1:1]};
                        borrow_out <= w_cell_bout;
                        r_state    <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_subtractor
// Description : Directed vector bench for serial_subtractor (WIDTH 8 and 2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8, start2;
    logic [7:0] a8, b8;
    logic [1:0] a2, b2;
    logic       busy8, done8, bo8;
    logic       busy2, done2, bo2;
    logic [7:0] diff8;
    logic [1:0] diff2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8)
    );

    serial_subtractor #(.WIDTH(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2),
        .busy(busy2), .done(done2), .diff(diff2), .borrow_out(bo2)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] d;
        logic       bo;
    } vec_t;

    task automatic check(input string name, input int actual, input int expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Launch one WIDTH=8 operation from IDLE and check latency, busy length, result.
    task automatic do_op8(input logic [7:0] ia, input logic [7:0] ib,
                          input int exp_d, input int exp_bo);
        int e;
        int busy_cnt;
        @(negedge clk);
        a8 = ia; b8 = ib; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; a8 = 8'hxx; b8 = 8'hxx;
        e = 0;
        busy_cnt = 0;
        while (!done8 && e < 40) begin
            if (busy8) busy_cnt++;
            @(negedge clk);
            e++;
        end
        check("latency8", e, 9);
        check("busy_cycles8", busy_cnt, 8);
        check("diff8", int'(diff8), exp_d);
        check("borrow8", int'(bo8), exp_bo);
        check("busy_in_done8", int'(busy8), 0);
        @(negedge clk);
        check("done_pulse8", int'(done8), 0);
    endtask

    initial begin
        vec_t vecs[7];
        int   e;
        int   dones;
        int   last_done;
        int   got_d;
        int   got_bo;
        logic seen;

        vecs[0] = '{8'd200, 8'd55,  8'd145, 1'b0};
        vecs[1] = '{8'd5,   8'd10,  8'd251, 1'b1};
        vecs[2] = '{8'd0,   8'd255, 8'd1,   1'b1};
        vecs[3] = '{8'd77,  8'd77,  8'd0,   1'b0};
        vecs[4] = '{8'd255, 8'd0,   8'd255, 1'b0};
        vecs[5] = '{8'd0,   8'd1,   8'd255, 1'b1};
        vecs[6] = '{8'd128, 8'd127, 8'd1,   1'b0};

        rst = 1'b1; start8 = 1'b0; start2 = 1'b0;
        a8 = '0; b8 = '0; a2 = '0; b2 = '0;
        repeat (3) @(negedge clk);
        check("rst_busy8", int'(busy8), 0);
        check("rst_done8", int'(done8), 0);
        check("rst_diff8", int'(diff8), 0);
        check("rst_borrow8", int'(bo8), 0);
        check("rst_busy2", int'(busy2), 0);
        check("rst_diff2", int'(diff2), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            do_op8(vecs[i].a, vecs[i].b, int'(vecs[i].d), int'(vecs[i].bo));
        end

        // Second start during SHIFT must be ignored.
        @(negedge clk);
        a8 = 8'd100; b8 = 8'd1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        dones = 0; got_d = -1; got_bo = -1;
        for (int c = 0; c < 25; c++) begin
            if (c == 3) begin
                a8 = 8'd3; b8 = 8'd9; start8 = 1'b1;
            end else begin
                start8 = 1'b0;
            end
            if (done8) begin
                dones++;
                got_d = int'(diff8);
                got_bo = int'(bo8);
            end
            @(negedge clk);
        end
        check("ignored_start_dones", dones, 1);
        check("ignored_start_diff", got_d, 99);
        check("ignored_start_borrow", got_bo, 0);

        // Reset during the 4th SHIFT cycle aborts the operation.
        a8 = 8'd20; b8 = 8'd30; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", int'(busy8), 0);
        check("abort_diff", int'(diff8), 0);
        check("abort_borrow", int'(bo8), 0);
        dones = 0;
        for (int c = 0; c < 15; c++) begin
            if (done8) dones++;
            @(negedge clk);
        end
        check("abort_no_done", dones, 0);
        do_op8(8'd9, 8'd4, 5, 0);

        // start held high: one result every 10 cycles, diff stable in between.
        @(negedge clk);
        a8 = 8'd10; b8 = 8'd3; start8 = 1'b1;
        dones = 0; last_done = -1; seen = 1'b0;
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            if (done8) begin
                if (last_done >= 0) check("b2b_period", c - last_done, 10);
                check("b2b_diff", int'(diff8), 7);
                last_done = c;
                dones++;
                seen = 1'b1;
            end else if (seen && diff8 !== 8'd7) begin
                check("b2b_stable", int'(diff8), 7);
            end
        end
        check("b2b_count", dones, 4);
        start8 = 1'b0;
        repeat (12) @(negedge clk);

        // WIDTH=2 build.
        a2 = 2'd1; b2 = 2'd2; start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        e = 0;
        while (!done2 && e < 20) begin
            @(negedge clk);
            e++;
        end
        check("latency2", e, 3);
        check("diff2", int'(diff2), 3);
        check("borrow2", int'(bo2), 1);
        @(negedge clk);
        check("done_pulse2", int'(done2), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
